regfile_mp: RTL

Parametrised multi-port integer register file for the core's decode/writeback path. It generalises the fixed 32×32, 2-read/1-write file in four ways: configurable width, depth and port counts; deterministic write-port priority; a hardware clear sequencer that zeroes every entry after reset or on request; and an optional read-forwarding path. Decode reads operands combinationally. Writeback ports commit on the clock edge.

---
 rtl/regfile_mp_pkg.sv | 27 ++
 rtl/regfile_clear_seq.sv | 61 ++++++
 rtl/regfile_mp.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types, default parameters and the write-port priority helper for regfile_mp.
// Optional forwarding is selected by REGFILE_MP_FORWARD_EN.
package regfile_mp_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } clr_state_e;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_NUM_RD   = 2;
   localparam int DEF_NUM_WR   = 2;
   localparam int DEF_ZERO_REG = 1;
   localparam int MAX_WR_PORTS = 4;

   // Highest set bit wins; callers only use the result when some bit is set.
   function automatic logic [1:0] top_hit(input logic [MAX_WR_PORTS-1:0] hits);
      logic [1:0] win;
      win = '0;
      for (int k = 0; k < MAX_WR_PORTS; k++) begin
         if (hits[k]) win = 2'(k);
      end
      return win;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry after reset or clear_req, writing zero,
// and holds the file not-ready until the sweep finishes.
module regfile_clear_seq
   import regfile_mp_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int AW       = $clog2(NUM_REGS)
)(
   input  logic          clk,
   input  logic          rst_i,
   input  logic          clear_req_i,
   output logic          ready_o,
   output logic          clr_we_o,
   output logic [AW-1:0] clr_addr_o
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

   clr_state_e    state_q;
   logic [AW-1:0] idx_q;
   logic          ready_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q <= CLEAR;
         idx_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               if (idx_q == LAST_IDX) begin
                  state_q <= IDLE;
                  idx_q   <= '0;
                  ready_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + AW'(1);
               end
            end
            IDLE: begin
               if (clear_req_i) begin
                  state_q <= CLEAR;
                  idx_q   <= '0;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= CLEAR;
               idx_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign ready_o    = ready_q;
   assign clr_we_o   = (state_q == CLEAR);
   assign clr_addr_o = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hardware clear sweep.
// Define REGFILE_MP_FORWARD_EN to forward same-cycle committing writes to reads.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int ZERO_REG = DEF_ZERO_REG,
   parameter int AW       = $clog2(NUM_REGS)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_req,
   output logic                   ready,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic [NUM_WR-1:0]      wr_en,
   input  logic [NUM_WR*AW-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data
);

   localparam int unsigned AW1 = AW + 1;
   localparam logic [AW:0] NUM_REGS_EXT = AW1'(NUM_REGS);

   logic [DATA_W-1:0]       mem_q [NUM_REGS];
   logic                    clr_we;
   logic [AW-1:0]           clr_addr;
   logic [NUM_WR-1:0]       wr_commit;
   logic [MAX_WR_PORTS-1:0] ent_hits [NUM_REGS];

   // Addresses that exist and are not the hardwired zero entry.
   function automatic logic addr_valid(input logic [AW-1:0] a);
      return ({1'b0, a} < NUM_REGS_EXT) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   regfile_clear_seq #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_clear_seq (
      .clk         (clk),
      .rst_i       (rst),
      .clear_req_i (clear_req),
      .ready_o     (ready),
      .clr_we_o    (clr_we),
      .clr_addr_o  (clr_addr)
   );

   always_comb begin
      for (int k = 0; k < NUM_WR; k++) begin
         wr_commit[k] = ready && wr_en[k] && addr_valid(wr_addr[k*AW +: AW]);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         ent_hits[i] = '0;
         for (int k = 0; k < NUM_WR; k++) begin
            ent_hits[i][k] = wr_commit[k] && ({1'b0, wr_addr[k*AW +: AW]} == AW1'(i));
         end
      end
   end

   // NOTE: storage has no reset; the clear sweep zeroes it after rst instead.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         if (|ent_hits[i]) begin
            mem_q[i] <= wr_data[int'(top_hit(ent_hits[i]))*DATA_W +: DATA_W];
         end
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] word;

      assign ra = rd_addr[p*AW +: AW];

`ifdef REGFILE_MP_FORWARD_EN
      logic [MAX_WR_PORTS-1:0] fwd_hits;

      always_comb begin
         fwd_hits = '0;
         for (int k = 0; k < NUM_WR; k++) begin
            fwd_hits[k] = wr_commit[k] && (wr_addr[k*AW +: AW] == ra);
         end
      end

      assign word = (|fwd_hits) ? wr_data[int'(top_hit(fwd_hits))*DATA_W +: DATA_W]
                                : mem_q[ra];
`else
      assign word = mem_q[ra];
`endif

      assign rd_data[p*DATA_W +: DATA_W] = (ready && addr_valid(ra)) ? word : '0;
   end

endmodule
